// File: rtl/spi_slave_regif.sv
// SPI mode 0 slave that decodes COMMAND/ADDRESS/PAYLOAD frames into register
// write strobes and register read requests, with read data shifted out on miso.
module spi_slave_regif #(
  parameter int                  CMD_BITS     = 8,
  parameter int                  ADDR_BITS    = 8,
  parameter int                  PAYLOAD_BITS = 8,
  parameter logic [CMD_BITS-1:0] CMD_WRITE    = CMD_BITS'(8'h02),
  parameter logic [CMD_BITS-1:0] CMD_READ     = CMD_BITS'(8'h03)
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    wr_en,
  output logic [ADDR_BITS-1:0]    wr_addr,
  output logic [PAYLOAD_BITS-1:0] wr_data,
  output logic                    rd_req,
  output logic [ADDR_BITS-1:0]    rd_addr,
  input  logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int MAX_AB   = (CMD_BITS > ADDR_BITS) ? CMD_BITS : ADDR_BITS;
  localparam int MAX_BITS = (MAX_AB > PAYLOAD_BITS) ? MAX_AB : PAYLOAD_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COMMAND, S_ADDRESS, S_READ, S_WRITE, S_IGNORE, S_DONE
  } state_t;

  // [0],[1] form the two-flop synchronizer; [2] is the edge-detect history
  logic [2:0] cs_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], cs};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  logic cs_sync, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_bit;

  assign cs_sync   = cs_q[1];
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2] & ~cs_sync;
  assign sclk_fall = ~sclk_q[1] & sclk_q[2] & ~cs_sync;
  assign mosi_bit  = mosi_q[1];

  state_t                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [CMD_BITS-1:0]     cmd_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic [PAYLOAD_BITS-1:0] tx_q;
  logic                    load_q;
  logic                    miso_q;
  logic                    wr_en_q;
  logic [ADDR_BITS-1:0]    wr_addr_q;
  logic [PAYLOAD_BITS-1:0] wr_data_q;
  logic                    rd_req_q;
  logic [ADDR_BITS-1:0]    rd_addr_q;
  logic                    busy_q;
  logic                    frame_err_q;

  logic [CMD_BITS-1:0]     cmd_d;
  logic [ADDR_BITS-1:0]    addr_d;
  logic [PAYLOAD_BITS-1:0] data_d;
  logic [CNT_W-1:0]        bit_cnt_inc;

  assign cmd_d       = CMD_BITS'({cmd_q, mosi_bit});
  assign addr_d      = ADDR_BITS'({addr_q, mosi_bit});
  assign data_d      = PAYLOAD_BITS'({data_q, mosi_bit});
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      load_q      <= 1'b0;
      // cs release ends any frame; only an unfinished decodable frame is an error
      if (state_q != S_IDLE && cs_rise) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        miso_q      <= 1'b0;
        tx_q        <= '0;
        bit_cnt_q   <= '0;
        frame_err_q <= (state_q != S_IGNORE) && (state_q != S_DONE);
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_fall) begin
              state_q   <= S_COMMAND;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
              miso_q    <= 1'b0;
            end
          end
          S_COMMAND: begin
            if (sclk_rise) begin
              cmd_q <= cmd_d;
              if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= S_ADDRESS;
              end else begin
                bit_cnt_q <= bit_cnt_inc;
              end
            end
          end
          S_ADDRESS: begin
            if (sclk_rise) begin
              addr_q <= addr_d;
              if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                bit_cnt_q <= '0;
                if (cmd_q == CMD_WRITE) begin
                  state_q <= S_WRITE;
                end else if (cmd_q == CMD_READ) begin
                  state_q   <= S_READ;
                  rd_req_q  <= 1'b1;
                  rd_addr_q <= addr_d;
                end else begin
                  state_q <= S_IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_inc;
              end
            end
          end
          S_READ: begin
            // rd_data is valid the cycle after rd_req, so capture one cycle later
            if (rd_req_q) begin
              load_q <= 1'b1;
            end
            if (load_q) begin
              tx_q <= rd_data;
            end else if (sclk_fall) begin
              miso_q <= tx_q[PAYLOAD_BITS-1];
              tx_q   <= {tx_q[PAYLOAD_BITS-2:0], 1'b0};
            end
            if (sclk_rise) begin
              if (bit_cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= S_DONE;
                miso_q    <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_inc;
              end
            end
          end
          S_WRITE: begin
            if (sclk_rise) begin
              data_q <= data_d;
              if (bit_cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= S_DONE;
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= data_d;
              end else begin
                bit_cnt_q <= bit_cnt_inc;
              end
            end
          end
          S_IGNORE, S_DONE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign miso      = miso_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: a bit-banged SPI master, a one-cycle
// latency register-read responder and strobe counters checked after each frame.
module tb_spi_slave_regif;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       busy;
  logic       frame_err;

  spi_slave_regif dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #4 sysclk = ~sysclk;

  int tests = 0;
  int fails = 0;

  int         wr_cnt, rd_cnt, ferr_cnt, both_cnt, miso_cnt;
  logic [7:0] last_wr_addr, last_wr_data, last_rd_addr;
  logic [7:0] rd_mem = 8'hC3;
  logic       req_d1 = 1'b0;
  logic       busy_mid;
  logic [31:0] rx;

  // Register-file responder: data appears for exactly one edge, the one after rd_req
  always @(negedge sysclk) begin
    rd_data = req_d1 ? rd_mem : 8'h00;
    req_d1  = rd_req;
    if (wr_en) begin
      wr_cnt++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
    if (rd_req) begin
      rd_cnt++;
      last_rd_addr = rd_addr;
    end
    if (frame_err) ferr_cnt++;
    if (wr_en && rd_req) both_cnt++;
    if (miso) miso_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt   = 0;
    rd_cnt   = 0;
    ferr_cnt = 0;
    both_cnt = 0;
    miso_cnt = 0;
  endtask

  task automatic shift_bits(input logic [31:0] word, input int nbits, input int half,
                            output logic [31:0] rx_o);
    rx_o = 32'h0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = word[i];
      wait_cycles(half);
      sclk = 1'b1;
      rx_o = {rx_o[30:0], miso};
      if (i == nbits - 1) busy_mid = busy;
      wait_cycles(half);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [31:0] word, input int nbits, input int half,
                          output logic [31:0] rx_o);
    cs = 1'b0;
    wait_cycles(half);
    shift_bits(word, nbits, half, rx_o);
    wait_cycles(half);
    cs   = 1'b1;
    mosi = 1'b0;
    wait_cycles(8);
  endtask

  initial begin
    rst_n = 1'b0;
    cs    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    clear_mon();
    wait_cycles(3);
    check("reset_outputs", 32'({miso, wr_en, rd_req, busy, frame_err, wr_addr, wr_data, rd_addr}), 32'h0);
    rst_n = 1'b1;
    wait_cycles(4);

    // 1: write at sysclk/8
    clear_mon();
    spi_xfer(32'h0215A7, 24, 4, rx);
    check("w1_wr_cnt", wr_cnt, 1);
    check("w1_wr_addr", last_wr_addr, 8'h15);
    check("w1_wr_data", last_wr_data, 8'hA7);
    check("w1_frame_err", ferr_cnt, 0);
    check("w1_busy_mid", busy_mid, 1'b1);
    check("w1_busy_end", busy, 1'b0);
    check("w1_miso_quiet", miso_cnt, 0);

    // 2: read at sysclk/8
    clear_mon();
    rd_mem = 8'hC3;
    spi_xfer(32'h031500, 24, 4, rx);
    check("r1_rd_cnt", rd_cnt, 1);
    check("r1_rd_addr", last_rd_addr, 8'h15);
    check("r1_miso_data", rx, 32'h000000C3);
    check("r1_wr_cnt", wr_cnt, 0);
    check("r1_strobe_overlap", both_cnt, 0);

    // 2b: read at sysclk/16
    clear_mon();
    rd_mem = 8'h5A;
    spi_xfer(32'h037F00, 24, 8, rx);
    check("r2_rd_addr", last_rd_addr, 8'h7F);
    check("r2_miso_data", rx, 32'h0000005A);

    // 3: unknown command
    clear_mon();
    spi_xfer(32'h7E01FF, 24, 4, rx);
    check("u_wr_cnt", wr_cnt, 0);
    check("u_rd_cnt", rd_cnt, 0);
    check("u_miso_quiet", miso_cnt, 0);
    check("u_busy_end", busy, 1'b0);

    // 4: abort after 12 bits, then a full write
    clear_mon();
    spi_xfer(32'h021, 12, 4, rx);
    check("a_frame_err", ferr_cnt, 1);
    check("a_wr_cnt", wr_cnt, 0);
    check("a_busy_end", busy, 1'b0);
    clear_mon();
    spi_xfer(32'h020155, 24, 4, rx);
    check("a2_wr_cnt", wr_cnt, 1);
    check("a2_wr_addr", last_wr_addr, 8'h01);
    check("a2_wr_data", last_wr_data, 8'h55);
    check("a2_frame_err", ferr_cnt, 0);

    // 5: overrun, 28 sclk cycles
    clear_mon();
    spi_xfer(32'h023C96F, 28, 4, rx);
    check("o_wr_cnt", wr_cnt, 1);
    check("o_wr_addr", last_wr_addr, 8'h3C);
    check("o_wr_data", last_wr_data, 8'h96);
    check("o_frame_err", ferr_cnt, 0);

    // 6: reset mid-ADDRESS, then a write at sysclk/16
    clear_mon();
    cs = 1'b0;
    wait_cycles(4);
    shift_bits(32'h021, 12, 4, rx);
    wait_cycles(4);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", 32'({miso, wr_en, rd_req, busy, frame_err, wr_addr, wr_data, rd_addr}), 32'h0);
    wait_cycles(3);
    cs = 1'b1;
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(4);
    check("rst_no_wr", wr_cnt, 0);
    check("rst_no_ferr", ferr_cnt, 0);
    clear_mon();
    spi_xfer(32'h02200F, 24, 8, rx);
    check("rw_wr_cnt", wr_cnt, 1);
    check("rw_wr_addr", last_wr_addr, 8'h20);
    check("rw_wr_data", last_wr_data, 8'h0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
